// File: rtl/bitmask_encoder_32to5_if.sv
// rtl/bitmask_encoder_32to5_if.sv - vector-in / index-out handshake bundle for the 32-to-5 bitmask encoder
interface bitmask_encoder_32to5_if;
  logic [31:0] i_vec;
  logic        i_vec_valid;
  logic        o_vec_ready;
  logic [4:0]  o_idx;
  logic        o_idx_valid;
  logic        i_idx_ready;
  logic        o_last;
  logic [5:0]  o_count;

  // Encoder side: takes vectors, produces indices
  modport slave (
    input  i_vec, i_vec_valid, i_idx_ready,
    output o_vec_ready, o_idx, o_idx_valid, o_last, o_count
  );

  // Producer/consumer side
  modport master (
    output i_vec, i_vec_valid, i_idx_ready,
    input  o_vec_ready, o_idx, o_idx_valid, o_last, o_count
  );
endinterface

// File: rtl/bitmask_encoder_32to5.sv
// rtl/bitmask_encoder_32to5.sv - sequential 32-to-5 encoder streaming one index per set bit
module bitmask_encoder_32to5 #(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  bitmask_encoder_32to5_if.slave       bus
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] mask;
  logic [4:0]  enc_idx;
  logic [5:0]  pop;
  logic        accept;
  logic        xfer;

  assign accept = bus.i_vec_valid & bus.o_vec_ready;
  assign xfer   = bus.o_idx_valid & bus.i_idx_ready;

  // Priority encode of the remaining bits; the last match in loop order wins
  always_comb begin
    enc_idx = '0;
    if (LSB_FIRST) begin
      for (int i = 31; i >= 0; i--) begin
        if (mask[i]) enc_idx = 5'(i);
      end
    end else begin
      for (int i = 0; i < 32; i++) begin
        if (mask[i]) enc_idx = 5'(i);
      end
    end
  end

  // Number of indices still to be emitted, including the current one
  always_comb begin
    pop = '0;
    for (int i = 0; i < 32; i++) begin
      pop = pop + {5'd0, mask[i]};
    end
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next state: zero vectors are swallowed without leaving IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept && (bus.i_vec != 32'd0)) state_nxt = BUSY;
      BUSY: if (xfer && bus.o_last)             state_nxt = IDLE;
      default:                                  state_nxt = IDLE;
    endcase
  end

  // Outputs straight from the mask so consecutive indices need no bubble
  always_comb begin
    bus.o_vec_ready = (state == IDLE) & i_rst_n;
    bus.o_idx_valid = (state == BUSY);
    bus.o_idx       = (state == BUSY) ? enc_idx : 5'd0;
    bus.o_count     = (state == BUSY) ? pop : 6'd0;
    bus.o_last      = (state == BUSY) & (pop == 6'd1);
  end

  // Mask: load on accept, clear the emitted bit on each transfer
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      mask <= '0;
    end else if (accept) begin
      mask <= bus.i_vec;
    end else if (xfer) begin
      mask <= mask & ~(32'd1 << bus.o_idx);
    end
  end

endmodule

// File: doc/bitmask_encoder_32to5.md
# bitmask_encoder_32to5

Sequential 32-to-5 encoder that converts a captured 32-bit multi-hot vector into a stream of 5-bit indices, one per set bit, in priority order. It is the inverse of the 5-to-32 select decoder. Producers include register-file write-enable masks, hazard scoreboards and pending-request vectors, which must be turned back into register addresses. It sits between a vector producer (valid/ready) and an index consumer (valid/ready) inside the single-cycle core's support logic.

## Interface
- LSB_FIRST, 1, 1: lowest set index is emitted first; 0: highest set index is emitted first
- i_clk  input  1  clock; all state updates on the rising edge
- i_rst_n  input  1  synchronous, active-low reset
- i_vec  input  32  multi-hot vector to encode
- i_vec_valid  input  1  i_vec is valid
- o_vec_ready  output  1  block can accept a vector
- o_idx  output  5  current index (bit position in the captured vector)
- o_idx_valid  output  1  o_idx is valid
- i_idx_ready  input  1  consumer accepts o_idx
- o_last  output  1  o_idx is the final index of the current vector
- o_count  output  6  number of set bits still pending, including the one on o_idx (0..32)

## Operation
- Internal state:
  - 32-bit mask register
  - FSM with two states, IDLE and BUSY
- IDLE:
  - o_vec_ready = 1, o_idx_valid = 0, o_count = 0.
  - A vector is accepted when i_vec_valid & o_vec_ready. On acceptance, mask <= i_vec.
  - If i_vec != 0, the FSM goes to BUSY. If i_vec == 0, the vector is consumed, no index is emitted and the FSM stays in IDLE.
- BUSY:
  - o_vec_ready = 0 and o_idx_valid = 1.
  - o_idx is the priority encode of the mask: the lowest set bit if LSB_FIRST=1, the highest set bit otherwise.
  - o_count = popcount(mask). o_last = (o_count == 1).
- Output handshake: transfer occurs when o_idx_valid & i_idx_ready.
  - On transfer: mask <= mask with bit o_idx cleared.
  - If o_last, the FSM goes to IDLE.
- Backpressure: while o_idx_valid & !i_idx_ready, o_idx, o_last and o_count hold stable and the mask is unchanged.
- i_vec is sampled only on acceptance. Changes to i_vec while in BUSY have no effect.
- o_idx, o_last and o_count are driven combinationally from the mask register, so there is no bubble between consecutive indices.
- o_vec_ready = (state == IDLE) & i_rst_n. No vector is accepted in a cycle where reset is asserted.

## Timing
- Reset: any rising edge with i_rst_n = 0 forces state = IDLE and mask = 0. Resulting outputs:
  - o_idx_valid = 0, o_idx = 0, o_last = 0, o_count = 0
  - o_vec_ready = 0 during reset, 1 from the first cycle after release
- Reset mid-stream: the current vector is abandoned and any remaining indices are dropped.
- Latency: vector accepted at edge N gives the first index valid in cycle N+1.
- Throughput while i_idx_ready is held high: one index per cycle. A vector with k set bits occupies cycles N+1..N+k.
- Return to IDLE: the last transfer at edge M gives o_vec_ready = 1 in cycle M+1. There is no same-cycle accept on the last transfer, so the minimum period between accepted non-zero vectors is k+1 cycles.
- Zero vector: accepted at edge N, and o_vec_ready stays 1 in cycle N+1, so back-to-back zero vectors are accepted every cycle.
- Full vector 0xFFFF_FFFF: o_count = 32 in the first BUSY cycle. Indices are 0..31 (LSB_FIRST=1) or 31..0 (LSB_FIRST=0). o_last is asserted only with the 32nd index.
- Single-bit vector: one BUSY cycle with o_count = 1 and o_last = 1.

## Test plan
- Reset:
  - Stimulus: hold i_rst_n = 0 for 3 cycles with i_vec_valid = 1 and i_vec = 0x0000_00FF.
  - Required: no capture, o_idx_valid = 0, o_vec_ready = 0, o_count = 0.
  - After release: o_vec_ready = 1.
- Basic stream, LSB_FIRST=1:
  - Stimulus: i_vec = 0x8000_0013, i_idx_ready = 1.
  - Required indices 0, 1, 4, 31 in consecutive cycles, with o_count 4, 3, 2, 1 and o_last only on 31.
  - o_vec_ready = 1 in the following cycle.
- Backpressure:
  - Stimulus: i_vec = 0x0000_0104, then i_idx_ready = 0 for 5 cycles.
  - Required: o_idx = 2, o_count = 2, o_last = 0, all stable for those 5 cycles.
  - Then release i_idx_ready: indices 2, then 8 with o_last = 1.
- Zero and full vectors:
  - Stimulus: i_vec = 0 on two consecutive cycles.
  - Required: both accepted, with no o_idx_valid.
  - Stimulus: i_vec = 0xFFFF_FFFF.
  - Required: 32 indices 0..31 on 32 consecutive cycles, o_count starting at 32.
  - Required: i_vec changes during BUSY are ignored.
- LSB_FIRST=0:
  - Stimulus: i_vec = 0x0000_0A01.
  - Required: indices 11, 9, 0, with o_last on 0.
- Reset mid-stream:
  - Stimulus: i_vec = 0x0000_00F0; assert i_rst_n = 0 after index 5 transfers.
  - Required: next cycle o_idx_valid = 0 and o_count = 0, with indices 6 and 7 never emitted.
  - After release: a new vector 0x1 yields index 0 with o_last = 1.
